// File: rtl/gol_pkg.sv
// Shared constants, FSM state type and grid helpers for the Game of Life scheduler.
// Build option GOL_TORUS_EN selects wrap-around ghost borders instead of hard-zero borders.
package gol_pkg;

   localparam int COLS     = 66;
   localparam int ROWS     = 50;
   localparam int V_ACTIVE = 480;
   localparam int FPG_W    = 6;
   localparam int CELLS    = COLS * ROWS;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_WAIT_VB = 2'd2,
      ST_SWAP    = 2'd3
   } gol_state_e;

   function automatic int idx(input int y, input int x);
      return y * COLS + x;
   endfunction

   // Border cells are either zero or ghost copies of the opposite interior edge.
   function automatic logic [CELLS-1:0] apply_border(input logic [CELLS-1:0] g);
      logic [CELLS-1:0] r;
      r = '0;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
`ifdef GOL_TORUS_EN
            int sy;
            int sx;
            sy = (y == 0) ? ROWS - 2 : ((y == ROWS - 1) ? 1 : y);
            sx = (x == 0) ? COLS - 2 : ((x == COLS - 1) ? 1 : x);
            r[idx(y, x)] = g[idx(sy, sx)];
`else
            if (y != 0 && y != ROWS - 1 && x != 0 && x != COLS - 1)
               r[idx(y, x)] = g[idx(y, x)];
`endif
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/gol_gen_scheduler_if.sv
// Control/display bundle between the scheduler (slave) and its user (master).
interface gol_gen_scheduler_if;
   import gol_pkg::*;

   // run is a level; step and load are single-cycle pulses sampled on the clock
   // edge they are high; gen_done is a single-cycle pulse coincident with the new grid.
   logic [9:0]       vcount;
   logic             run;
   logic             step;
   logic             load;
   logic [CELLS-1:0] seed;
   logic [FPG_W-1:0] frames_per_gen;
   logic [CELLS-1:0] pixels_out;
   logic             busy;
   logic             gen_done;
   logic [15:0]      gen_count;
   gol_state_e       dbg_state;

   modport master (
      output vcount, run, step, load, seed, frames_per_gen,
      input  pixels_out, busy, gen_done, gen_count, dbg_state
   );

   modport slave (
      input  vcount, run, step, load, seed, frames_per_gen,
      output pixels_out, busy, gen_done, gen_count, dbg_state
   );

endinterface

// File: rtl/gol_row_eval.sv
// Combinational Life rule for one 66-cell row; edge columns of the result are always zero.
module gol_row_eval
   import gol_pkg::*;
(
   input  logic [COLS-1:0] row_up_i,
   input  logic [COLS-1:0] row_mid_i,
   input  logic [COLS-1:0] row_dn_i,
   output logic [COLS-1:0] row_next_o
);

   function automatic logic cell_next(input logic [2:0] up, input logic [2:0] mid,
                                      input logic [2:0] dn);
      logic [3:0] n;
      n = 4'(up[0]) + 4'(up[1]) + 4'(up[2]) + 4'(mid[0]) + 4'(mid[2])
        + 4'(dn[0]) + 4'(dn[1]) + 4'(dn[2]);
      return (n == 4'd3) || (mid[1] && n == 4'd2);
   endfunction

   always_comb begin
      row_next_o = '0;
      for (int c = 1; c < COLS - 1; c++)
         row_next_o[c] = cell_next(row_up_i[c-1 +: 3], row_mid_i[c-1 +: 3], row_dn_i[c-1 +: 3]);
   end

endmodule

// File: rtl/gol_gen_scheduler.sv
// Game of Life generation sequencer: row-per-cycle compute into a shadow grid, swap in vblank.
// Build option GOL_TORUS_EN gives a toroidal world (see gol_pkg::apply_border).
module gol_gen_scheduler
   import gol_pkg::*;
(
   input logic              clk,
   input logic              reset,
   gol_gen_scheduler_if.slave bus
);

   gol_state_e       state_q;
   logic [CELLS-1:0] pixels_q;
   logic [CELLS-1:0] shadow_q;
   logic [5:0]       row_q;
   logic [FPG_W-1:0] div_q;
   logic [9:0]       vcount_prev_q;
   logic             pend_q;
   logic             gen_done_q;
   logic [15:0]      gen_count_q;

   logic             frame_tick;
   logic             start;
   logic             req;
   logic [FPG_W-1:0] div_max;
   logic [COLS-1:0]  row_up;
   logic [COLS-1:0]  row_mid;
   logic [COLS-1:0]  row_dn;
   logic [COLS-1:0]  row_next;

   assign frame_tick = (bus.vcount == 10'(V_ACTIVE)) && (vcount_prev_q != 10'(V_ACTIVE));
   assign div_max    = (bus.frames_per_gen == '0) ? '0 : bus.frames_per_gen - FPG_W'(1);
   assign start      = bus.run && frame_tick && (div_q >= div_max);
   assign req        = start || (bus.step && !bus.run);

   assign row_up  = pixels_q[(int'(row_q) - 1) * COLS +: COLS];
   assign row_mid = pixels_q[int'(row_q) * COLS +: COLS];
   assign row_dn  = pixels_q[(int'(row_q) + 1) * COLS +: COLS];

   gol_row_eval u_row_eval (
      .row_up_i   (row_up),
      .row_mid_i  (row_mid),
      .row_dn_i   (row_dn),
      .row_next_o (row_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         vcount_prev_q <= '0;
      end else begin
         vcount_prev_q <= bus.vcount;
         if (bus.load || !bus.run)
            div_q <= '0;
         else if (frame_tick)
            div_q <= (div_q >= div_max) ? '0 : div_q + FPG_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pixels_q    <= '0;
         shadow_q    <= '0;
         row_q       <= 6'd1;
         pend_q      <= 1'b0;
         gen_done_q  <= 1'b0;
         gen_count_q <= '0;
      end else if (bus.load) begin
         // Load wins over everything, including a same-cycle request or swap.
         state_q     <= ST_IDLE;
         pixels_q    <= apply_border(bus.seed);
         shadow_q    <= '0;
         row_q       <= 6'd1;
         pend_q      <= 1'b0;
         gen_done_q  <= 1'b0;
         gen_count_q <= '0;
      end else begin
         gen_done_q <= 1'b0;
         if (state_q != ST_IDLE && req)
            pend_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (req || pend_q) begin
                  state_q <= ST_COMPUTE;
                  row_q   <= 6'd1;
                  pend_q  <= 1'b0;
               end
            end
            ST_COMPUTE: begin
               shadow_q[int'(row_q) * COLS +: COLS] <= row_next;
               if (row_q == 6'(ROWS - 2))
                  state_q <= ST_WAIT_VB;
               else
                  row_q <= row_q + 6'd1;
            end
            ST_WAIT_VB: begin
               if (bus.vcount >= 10'(V_ACTIVE))
                  state_q <= ST_SWAP;
            end
            ST_SWAP: begin
               pixels_q    <= apply_border(shadow_q);
               gen_count_q <= gen_count_q + 16'd1;
               gen_done_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.pixels_out = pixels_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.gen_done   = gen_done_q;
   assign bus.gen_count  = gen_count_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Self-checking bench for gol_gen_scheduler against an array-based Life model.
`timescale 1ns/1ps
module tb_gol_gen_scheduler;
   import gol_pkg::*;

   logic clk;
   logic reset;
   logic half;
   int   n_checks;
   int   n_pass;

   gol_gen_scheduler_if bus();

   gol_gen_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset / vcount ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // vcount advances every other clock over a 525-line frame
   initial begin
      bus.vcount = '0;
      half = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         half = ~half;
         if (half) bus.vcount = (bus.vcount == 10'd524) ? 10'd0 : bus.vcount + 10'd1;
      end
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_grid(input string tag, input logic [CELLS-1:0] g);
      for (int y = 0; y < ROWS; y++)
         check($sformatf("%s_row%0d", tag, y), 128'(bus.pixels_out[y*COLS +: COLS]),
               128'(g[y*COLS +: COLS]));
   endtask

   // ---------------- reference model ----------------
   bit mdl[ROWS][COLS];

   function automatic void model_border();
      bit tmp[ROWS][COLS];
      tmp = mdl;
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++) begin
            if (y == 0 || y == ROWS-1 || x == 0 || x == COLS-1) begin
`ifdef GOL_TORUS_EN
               int sy;
               int sx;
               sy = (y == 0) ? ROWS-2 : (y == ROWS-1) ? 1 : y;
               sx = (x == 0) ? COLS-2 : (x == COLS-1) ? 1 : x;
               mdl[y][x] = tmp[sy][sx];
`else
               mdl[y][x] = 1'b0;
`endif
            end
         end
   endfunction

   function automatic void model_load(input logic [CELLS-1:0] s);
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++)
            mdl[y][x] = s[y*COLS + x];
      model_border();
   endfunction

   function automatic void model_step();
      bit nxt[ROWS][COLS];
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++) begin
            int n;
            nxt[y][x] = 1'b0;
            if (y > 0 && y < ROWS-1 && x > 0 && x < COLS-1) begin
               n = 0;
               for (int dy = -1; dy <= 1; dy++)
                  for (int dx = -1; dx <= 1; dx++)
                     if (dy != 0 || dx != 0) n += int'(mdl[y+dy][x+dx]);
               nxt[y][x] = (n == 3) || (mdl[y][x] && n == 2);
            end
         end
      mdl = nxt;
      model_border();
   endfunction

   function automatic logic [CELLS-1:0] model_flat();
      logic [CELLS-1:0] f;
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++)
            f[y*COLS + x] = mdl[y][x];
      return f;
   endfunction

   function automatic logic [CELLS-1:0] rand_seed();
      logic [CELLS-1:0] s;
      for (int i = 0; i < CELLS; i++) s[i] = 1'($urandom_range(0, 1));
      return s;
   endfunction

   // ---------------- scoreboard ----------------
   logic [CELLS-1:0] exp_q[$];
   int               cnt_q[$];
   int               gd_ft[$];
   int               exp_gen;
   int               gd_cnt;
   int               ft_cnt;
   int               comp_run;
   int               last_comp_len;
   logic [9:0]       prev_vc;

   initial begin
      gd_cnt = 0;
      ft_cnt = 0;
      comp_run = 0;
      last_comp_len = 0;
      prev_vc = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_vc = bus.vcount;
            comp_run = 0;
         end else begin
            if (bus.vcount == 10'(V_ACTIVE) && prev_vc != 10'(V_ACTIVE)) ft_cnt++;
            prev_vc = bus.vcount;
            if (bus.dbg_state == ST_COMPUTE) comp_run++;
            else if (comp_run != 0) begin
               last_comp_len = comp_run;
               comp_run = 0;
            end
            if (bus.gen_done) begin
               gd_cnt++;
               gd_ft.push_back(ft_cnt);
               if (exp_q.size() == 0) check("spurious_gen_done", 128'(1), 128'(0));
               else begin
                  check_grid($sformatf("gen%0d", gd_cnt), exp_q.pop_front());
                  check("gen_count", 128'(bus.gen_count), 128'(cnt_q.pop_front()));
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [CELLS-1:0] s);
      tick();
      bus.seed = s;
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      model_load(s);
      exp_q.delete();
      cnt_q.delete();
      exp_gen = 0;
   endtask

   task automatic expect_gen();
      model_step();
      exp_gen++;
      exp_q.push_back(model_flat());
      cnt_q.push_back(exp_gen);
   endtask

   task automatic pulse_step();
      tick();
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
   endtask

   task automatic wait_gd(input int target, input int budget);
      int n;
      n = 0;
      while (gd_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("gen_done_within_budget", 128'(gd_cnt >= target), 128'(1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [CELLS-1:0] s;
      logic [CELLS-1:0] snap;
      int base;
      int lat;
      int n;
      logic early;

      n_checks = 0;
      n_pass = 0;
      exp_gen = 0;
      reset = 1'b1;
      bus.run = 1'b0;
      bus.step = 1'b0;
      bus.load = 1'b0;
      bus.seed = '0;
      bus.frames_per_gen = FPG_W'(1);
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_pixels_any", 128'(|bus.pixels_out), 128'(0));
      check("rst_gen_count", 128'(bus.gen_count), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_gen_done", 128'(bus.gen_done), 128'(0));
      check("rst_state", 128'(bus.dbg_state), 128'(ST_IDLE));

      // blinker
      s = '0;
      s[idx(10, 10)] = 1'b1;
      s[idx(10, 11)] = 1'b1;
      s[idx(10, 12)] = 1'b1;
      do_load(s);
      @(negedge clk);
      check_grid("blinker_load", model_flat());
      expect_gen();
      base = gd_cnt;
      pulse_step();
      wait_gd(base + 1, 3000);
      check("blinker_compute_len", 128'(last_comp_len), 128'(48));
      check("blinker_v9", 128'(bus.pixels_out[idx(9, 11)]), 128'(1));
      check("blinker_h10", 128'(bus.pixels_out[idx(10, 10)]), 128'(0));

      // random seeds (borders included) with random step timing
      for (int t = 0; t < 3; t++) begin
         do_load(rand_seed());
         @(negedge clk);
         check_grid($sformatf("rand%0d_load", t), model_flat());
         repeat ($urandom_range(0, 300)) tick();
         expect_gen();
         base = gd_cnt;
         pulse_step();
         wait_gd(base + 1, 3000);
         check("rand_compute_len", 128'(last_comp_len), 128'(48));
      end

      // block still life, free-running every 2 frames
      s = '0;
      s[idx(20, 30)] = 1'b1;
      s[idx(20, 31)] = 1'b1;
      s[idx(21, 30)] = 1'b1;
      s[idx(21, 31)] = 1'b1;
      do_load(s);
      bus.frames_per_gen = FPG_W'(2);
      repeat (3) expect_gen();
      base = gd_cnt;
      bus.run = 1'b1;
      wait_gd(base + 3, 10000);
      bus.run = 1'b0;
      check("block_spacing_a", 128'(gd_ft[base+1] - gd_ft[base]), 128'(2));
      check("block_spacing_b", 128'(gd_ft[base+2] - gd_ft[base+1]), 128'(2));

      // tear-free swap for a request at vcount=100
      do_load(rand_seed());
      n = 0;
      while (bus.vcount != 10'd100 && n < 3000) begin
         tick();
         n++;
      end
      check("reach_vcount_100", 128'(bus.vcount), 128'(100));
      snap = bus.pixels_out;
      expect_gen();
      pulse_step();
      early = 1'b0;
      lat = 0;
      while (!bus.gen_done && lat < 3000) begin
         @(negedge clk);
         lat++;
         if (!bus.gen_done && bus.pixels_out != snap) early = 1'b1;
      end
      check("tear_free", 128'(early), 128'(0));
      check("swap_in_vblank", 128'(bus.vcount >= 10'(V_ACTIVE)), 128'(1));
      check("latency_min", 128'(lat >= 50), 128'(1));
      repeat (2) tick();

      // load in the middle of COMPUTE abandons the generation
      do_load(rand_seed());
      expect_gen();
      base = gd_cnt;
      pulse_step();
      repeat (19) tick();
      s = rand_seed();
      do_load(s);
      @(negedge clk);
      check("midload_busy", 128'(bus.busy), 128'(0));
      check("midload_gen_count", 128'(bus.gen_count), 128'(0));
      check_grid("midload", model_flat());
      repeat (1200) tick();
      check("midload_no_gen_done", 128'(gd_cnt), 128'(base));

      // steps while busy: one is latched, the third is dropped
      do_load(rand_seed());
      base = gd_cnt;
      expect_gen();
      pulse_step();
      repeat (5) tick();
      expect_gen();
      pulse_step();
      repeat (5) tick();
      pulse_step();
      wait_gd(base + 2, 4000);
      repeat (1200) tick();
      check("busy_step_total", 128'(gd_cnt), 128'(base + 2));
      check("busy_step_count", 128'(bus.gen_count), 128'(2));

      // frames_per_gen=0 runs every frame
      bus.frames_per_gen = '0;
      repeat (2) expect_gen();
      base = gd_cnt;
      bus.run = 1'b1;
      wait_gd(base + 2, 5000);
      bus.run = 1'b0;
      check("fpg0_spacing", 128'(gd_ft[base+1] - gd_ft[base]), 128'(1));

      // glider crossing the lower-right edge
      s = '0;
      s[idx(46, 63)] = 1'b1;
      s[idx(47, 64)] = 1'b1;
      s[idx(48, 62)] = 1'b1;
      s[idx(48, 63)] = 1'b1;
      s[idx(48, 64)] = 1'b1;
      do_load(s);
      for (int g = 0; g < 4; g++) begin
         expect_gen();
         base = gd_cnt;
         pulse_step();
         wait_gd(base + 1, 3000);
      end

      repeat (5) tick();
      check("exp_q_drained", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
